// File: rtl/inst_queue.sv
// Instruction prefetch queue: a first-word-fall-through FIFO of {pc, instr} pairs
// between fetch and decode, with a branch/jump flush and a saturating flush-drop counter.
module inst_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_pc,
  input  logic [DW-1:0] in_instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_pc,
  output logic [DW-1:0] out_instr,
  output logic [AW:0]   count,
  output logic [7:0]    flush_drops
);

  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [DW-1:0] pcMem_q    [DEPTH];
  logic [DW-1:0] instrMem_q [DEPTH];

  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    drops_q, drops_d;

  logic          push;
  logic          pop;
  logic [8:0]    dropSum;

  // Handshake depends only on registered occupancy, so a full queue refuses
  // a push even while it pops and there is no combinational bypass.
  assign in_ready  = (count_q != FullCount);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_pc      = out_valid ? pcMem_q[rdPtr_q]    : '0;
  assign out_instr   = out_valid ? instrMem_q[rdPtr_q] : '0;
  assign count       = count_q;
  assign flush_drops = drops_q;

  assign dropSum = {1'b0, drops_q} + 9'(count_q);

  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    drops_d = drops_q;
    if (flush) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
      drops_d = dropSum[8] ? 8'hFF : dropSum[7:0];
    end else begin
      if (push) wrPtr_d = wrPtr_q + 1'b1;
      if (pop)  rdPtr_d = rdPtr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
      drops_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
      drops_q <= drops_d;
    end
  end

  // Storage is deliberately left unreset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pcMem_q[wrPtr_q]    <= in_pc;
      instrMem_q[wrPtr_q] <= in_instr;
    end
  end

`ifndef SYNTHESIS
  countBound: assert property (@(posedge clk) disable iff (rst) count_q <= FullCount);
  ptrConsistent: assert property (@(posedge clk) disable iff (rst)
    (wrPtr_q - rdPtr_q) == count_q[AW-1:0]);
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue: reset, fill/drain, streaming,
// full-queue refusal, flush behaviour and flush-drop saturation.
module tb_inst_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [31:0] inPc;
  logic [31:0] inInstr;
  logic        outValid;
  logic        outReady;
  logic [31:0] outPc;
  logic [31:0] outInstr;
  logic [2:0]  count;
  logic [7:0]  flushDrops;

  int checks;
  int failures;

  inst_queue #(.DEPTH(4), .AW(2), .DW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .in_pc      (inPc),
    .in_instr   (inInstr),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .out_pc     (outPc),
    .out_instr  (outInstr),
    .count      (count),
    .flush_drops(flushDrops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc,
                               input logic [31:0] instr, input logic rdy,
                               input logic fl);
    inValid  = v;
    inPc     = pc;
    inInstr  = instr;
    outReady = rdy;
    flush    = fl;
    step();
  endtask

  initial begin
    int expDrops;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    flush    = 1'b0;
    inValid  = 1'b0;
    inPc     = '0;
    inInstr  = '0;
    outReady = 1'b0;

    // T1: reset values, then asynchronous reset mid-cycle
    #1;
    checkOutput("rst_count", 32'(count), 0);
    checkOutput("rst_out_valid", 32'(outValid), 0);
    checkOutput("rst_in_ready", 32'(inReady), 1);
    checkOutput("rst_drops", 32'(flushDrops), 0);
    step();
    rst = 1'b0;
    applyStimulus(1'b1, 32'h100, 32'h55, 1'b0, 1'b0);
    checkOutput("t1_latency_valid", 32'(outValid), 1);
    checkOutput("t1_latency_instr", outInstr, 32'h55);
    applyStimulus(1'b1, 32'h104, 32'h56, 1'b0, 1'b0);
    checkOutput("t1_count_before", 32'(count), 2);
    inValid = 1'b0;
    #3 rst = 1'b1;
    #1;
    checkOutput("t1_async_count", 32'(count), 0);
    checkOutput("t1_async_out_valid", 32'(outValid), 0);
    checkOutput("t1_async_in_ready", 32'(inReady), 1);
    checkOutput("t1_async_out_instr", outInstr, 0);
    step();
    rst = 1'b0;

    // T2: fill with decode stalled, refuse a fifth push, then drain in order
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 32'(i * 4), 32'hA0 + 32'(i), 1'b0, 1'b0);
    checkOutput("t2_full_count", 32'(count), 4);
    checkOutput("t2_full_in_ready", 32'(inReady), 0);
    applyStimulus(1'b1, 32'h10, 32'hA4, 1'b0, 1'b0);
    checkOutput("t2_refused_count", 32'(count), 4);
    checkOutput("t2_stable_instr", outInstr, 32'hA0);
    inValid  = 1'b0;
    outReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t2_drain_instr%0d", i), outInstr, 32'hA0 + 32'(i));
      checkOutput($sformatf("t2_drain_pc%0d", i), outPc, 32'(i * 4));
      step();
    end
    checkOutput("t2_empty_valid", 32'(outValid), 0);
    checkOutput("t2_empty_instr", outInstr, 0);
    checkOutput("t2_empty_count", 32'(count), 0);

    // T3: steady push+pop at count 2 across pointer wrap
    applyStimulus(1'b1, 32'h200, 32'hB0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h204, 32'hB1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("t3_head%0d", k), outInstr, 32'hB0 + 32'(k));
      applyStimulus(1'b1, 32'h208 + 32'(k * 4), 32'hB2 + 32'(k), 1'b1, 1'b0);
      checkOutput($sformatf("t3_count%0d", k), 32'(count), 2);
    end
    inValid = 1'b0;
    for (int k = 10; k < 12; k++) begin
      checkOutput($sformatf("t3_tail%0d", k), outInstr, 32'hB0 + 32'(k));
      step();
    end
    checkOutput("t3_empty", 32'(count), 0);

    // T4: full queue pops but refuses the same-cycle push
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 32'h300 + 32'(i * 4), 32'hC0 + 32'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h3F0, 32'hC9, 1'b1, 1'b0);
    checkOutput("t4_count", 32'(count), 3);
    checkOutput("t4_in_ready", 32'(inReady), 1);
    inValid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      checkOutput($sformatf("t4_drain%0d", i), outInstr, 32'hC0 + 32'(i));
      step();
    end
    checkOutput("t4_no_refused_word", 32'(outValid), 0);

    // T5: flush at count 3 with a same-cycle push
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'h400 + 32'(i * 4), 32'hD0 + 32'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h40C, 32'hD3, 1'b1, 1'b1);
    checkOutput("t5_count", 32'(count), 0);
    checkOutput("t5_out_valid", 32'(outValid), 0);
    checkOutput("t5_drops", 32'(flushDrops), 3);
    checkOutput("t5_in_ready", 32'(inReady), 1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("t5_push_absent", 32'(count), 0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    checkOutput("t5_empty_flush_drops", 32'(flushDrops), 3);
    checkOutput("t5_empty_flush_count", 32'(count), 0);

    // T6: repeated flushes of a full queue saturate the drop counter
    expDrops = 3;
    for (int r = 0; r < 70; r++) begin
      for (int i = 0; i < 4; i++)
        applyStimulus(1'b1, 32'h500 + 32'(i * 4), 32'hE0 + 32'(i), 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      expDrops = (expDrops + 4 > 255) ? 255 : expDrops + 4;
      checkOutput($sformatf("t6_drops%0d", r), 32'(flushDrops), 32'(expDrops));
    end
    checkOutput("t6_final_count", 32'(count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
